// File: rtl/exu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exu_pkg
//  Description : Shared definitions for the execute/writeback unit: packed
//                dynamic-instruction field layout, instruction-type codes,
//                ALU operation encodings and EXU state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package exu_pkg;

    // Basic widths
    localparam int XLEN       = 32;
    localparam int REGIDX_W   = 5;
    localparam int SHAMT_W    = 5;

    // Packed dynamic-instruction layout (LSB first)
    localparam int INVLD_BIT   = 0;
    localparam int USE_RD_BIT  = 1;
    localparam int USE_RS1_BIT = 2;
    localparam int USE_RS2_BIT = 3;
    localparam int USE_IMM_BIT = 4;
    localparam int INSTYPE_OFF = 5;
    localparam int INSTYPE_W   = 3;
    localparam int ALUOP_OFF   = 8;
    localparam int ALUOP_W     = 4;
    localparam int RD_OFF      = 12;
    localparam int PC_OFF      = RD_OFF + REGIDX_W;   // 17
    localparam int IMM_OFF     = PC_OFF + XLEN;       // 49
    localparam int RS2VAL_OFF  = IMM_OFF + XLEN;      // 81
    localparam int RS1VAL_OFF  = RS2VAL_OFF + XLEN;   // 113
    localparam int DYN_INST_W  = RS1VAL_OFF + XLEN;   // 145

    // Instruction-type codes
    localparam logic [INSTYPE_W-1:0] INST_R     = 3'd0;
    localparam logic [INSTYPE_W-1:0] INST_I     = 3'd1;
    localparam logic [INSTYPE_W-1:0] INST_S     = 3'd2;
    localparam logic [INSTYPE_W-1:0] INST_B     = 3'd3;
    localparam logic [INSTYPE_W-1:0] INST_LUI   = 3'd4;
    localparam logic [INSTYPE_W-1:0] INST_AUIPC = 3'd5;
    localparam logic [INSTYPE_W-1:0] INST_J     = 3'd6;

    // ALU operations, encoded as {instr[30], funct3}
    localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 4'b0000;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 4'b1000;
    localparam logic [ALUOP_W-1:0] ALUOP_SLL  = 4'b0001;
    localparam logic [ALUOP_W-1:0] ALUOP_SLT  = 4'b0010;
    localparam logic [ALUOP_W-1:0] ALUOP_SLTU = 4'b0011;
    localparam logic [ALUOP_W-1:0] ALUOP_XOR  = 4'b0100;
    localparam logic [ALUOP_W-1:0] ALUOP_SRL  = 4'b0101;
    localparam logic [ALUOP_W-1:0] ALUOP_SRA  = 4'b1101;
    localparam logic [ALUOP_W-1:0] ALUOP_OR   = 4'b0110;
    localparam logic [ALUOP_W-1:0] ALUOP_AND  = 4'b0111;

    // EXU state encodings
    localparam logic [1:0] EXU_IDLE  = 2'd0;
    localparam logic [1:0] EXU_EXEC  = 2'd1;
    localparam logic [1:0] EXU_SHIFT = 2'd2;
    localparam logic [1:0] EXU_WB    = 2'd3;

    // True for the three shift operations
    function automatic logic is_shift_op(input logic [ALUOP_W-1:0] op);
        return (op == ALUOP_SLL) || (op == ALUOP_SRL) || (op == ALUOP_SRA);
    endfunction

endpackage : exu_pkg
`default_nettype wire

// File: rtl/exu_alu.sv
`default_nettype none
// ============================================================================
//  Module      : exu_alu
//  Description : Purely combinational RV32I ALU. Shift operations use a
//                barrel shifter unless EXU_ITER_SHIFT_EN is defined, in which
//                case shifts pass operand A through (shift by zero) and the
//                EXU performs the shift iteratively.
//  Macro       : EXU_ITER_SHIFT_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module exu_alu
    import exu_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int SHCNT_W    = SHAMT_W
) (
    input  logic [ALUOP_W-1:0]    alu_op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result
);

`ifndef EXU_ITER_SHIFT_EN
    logic [SHCNT_W-1:0] w_shamt;
    assign w_shamt = b[SHCNT_W-1:0];
`endif

    // Operation select; unknown encodings yield zero
    always_comb begin
        result = '0;
        case (alu_op)
            ALUOP_ADD:  result = a + b;
            ALUOP_SUB:  result = a - b;
            ALUOP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALUOP_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            ALUOP_XOR:  result = a ^ b;
            ALUOP_OR:   result = a | b;
            ALUOP_AND:  result = a & b;
`ifdef EXU_ITER_SHIFT_EN
            ALUOP_SLL,
            ALUOP_SRL,
            ALUOP_SRA:  result = a;
`else
            ALUOP_SLL:  result = a << w_shamt;
            ALUOP_SRL:  result = a >> w_shamt;
            ALUOP_SRA:  result = $signed(a) >>> w_shamt;
`endif
            default:    result = '0;
        endcase
    end

endmodule : exu_alu
`default_nettype wire

// File: rtl/exu.sv
`default_nettype none
// ============================================================================
//  Module      : exu
//  Description : Execute/writeback unit of the single-issue RV32I core.
//                Accepts a packed decoded instruction over valid/ready,
//                computes the ALU result and drives the register-file
//                writeback triple. IDLE -> EXEC -> (SHIFT) -> WB -> IDLE.
//  Macro       : EXU_ITER_SHIFT_EN - shifts run one bit per cycle in SHIFT
//  Revision    : 1.0 - initial release
// ============================================================================
module exu
    import exu_pkg::*;
#(
    parameter int DATA_WIDTH     = XLEN,
    parameter int RD_LEN_STA     = REGIDX_W,
    parameter int DYN_INST_WIDTH = DYN_INST_W,
    parameter int SHCNT_W        = SHAMT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DYN_INST_WIDTH-1:0] dyn_instr_i,
    input  logic                      dyn_vld_i,
    output logic                      dyn_rdy_o,
    output logic [RD_LEN_STA-1:0]     rd_o,
    output logic [DATA_WIDTH-1:0]     wrtbck_dat_o,
    output logic                      wrtbck_en_o,
    output logic                      illegal_o,
    output logic                      busy_o
);

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic [DYN_INST_WIDTH-1:0] r_instr;
    logic [DATA_WIDTH-1:0]     r_result;

    // Fields of the latched instruction
    logic                  w_invld;
    logic                  w_use_rd;
    logic                  w_use_rs1;
    logic                  w_use_imm;
    logic [INSTYPE_W-1:0]  w_instype;
    logic [ALUOP_W-1:0]    w_aluop;
    logic [RD_LEN_STA-1:0] w_rd;
    logic [DATA_WIDTH-1:0] w_pc;
    logic [DATA_WIDTH-1:0] w_imm;
    logic [DATA_WIDTH-1:0] w_rs1val;
    logic [DATA_WIDTH-1:0] w_rs2val;
    logic [DATA_WIDTH-1:0] w_opa;
    logic [DATA_WIDTH-1:0] w_opb;
    logic [DATA_WIDTH-1:0] w_alu_res;
    logic                  w_unused_use_rs2;

    assign w_invld          = r_instr[INVLD_BIT];
    assign w_use_rd         = r_instr[USE_RD_BIT];
    assign w_use_rs1        = r_instr[USE_RS1_BIT];
    assign w_use_imm        = r_instr[USE_IMM_BIT];
    assign w_unused_use_rs2 = r_instr[USE_RS2_BIT];
    assign w_instype        = r_instr[INSTYPE_OFF +: INSTYPE_W];
    assign w_aluop          = r_instr[ALUOP_OFF +: ALUOP_W];
    assign w_rd             = r_instr[RD_OFF +: RD_LEN_STA];
    assign w_pc             = r_instr[PC_OFF +: DATA_WIDTH];
    assign w_imm            = r_instr[IMM_OFF +: DATA_WIDTH];
    assign w_rs2val         = r_instr[RS2VAL_OFF +: DATA_WIDTH];
    assign w_rs1val         = r_instr[RS1VAL_OFF +: DATA_WIDTH];

    // AUIPC adds to pc, LUI adds to zero, otherwise rs1 when used
    assign w_opa = (w_instype == INST_AUIPC) ? w_pc :
                   (w_instype == INST_LUI)   ? '0   :
                   w_use_rs1                 ? w_rs1val : '0;
    assign w_opb = w_use_imm ? w_imm : w_rs2val;

    exu_alu #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHCNT_W    (SHCNT_W)
    ) u_alu (
        .alu_op (w_aluop),
        .a      (w_opa),
        .b      (w_opb),
        .result (w_alu_res)
    );

`ifdef EXU_ITER_SHIFT_EN
    logic [SHCNT_W-1:0] r_cnt;
    logic               w_iter_shift;
    // A zero shift amount needs no iterations and retires like any other op
    assign w_iter_shift = is_shift_op(w_aluop) && (w_opb[SHCNT_W-1:0] != '0);
`endif

    assign rd_o         = w_rd;
    assign wrtbck_dat_o = r_result;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= EXU_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and control outputs
    always_comb begin
        w_state_nxt = r_state;
        dyn_rdy_o   = 1'b0;
        busy_o      = 1'b1;
        wrtbck_en_o = 1'b0;
        illegal_o   = 1'b0;
        case (r_state)
            EXU_IDLE: begin
                dyn_rdy_o = 1'b1;
                busy_o    = 1'b0;
                if (dyn_vld_i) w_state_nxt = EXU_EXEC;
            end
            EXU_EXEC: begin
`ifdef EXU_ITER_SHIFT_EN
                if (!w_invld && w_iter_shift) w_state_nxt = EXU_SHIFT;
                else                          w_state_nxt = EXU_WB;
`else
                w_state_nxt = EXU_WB;
`endif
            end
`ifdef EXU_ITER_SHIFT_EN
            EXU_SHIFT: begin
                if (r_cnt == SHCNT_W'(1)) w_state_nxt = EXU_WB;
            end
`endif
            EXU_WB: begin
                wrtbck_en_o = w_use_rd && (w_rd != '0) && !w_invld;
                illegal_o   = w_invld;
                w_state_nxt = EXU_IDLE;
            end
            default: w_state_nxt = EXU_IDLE;
        endcase
    end

    // Instruction latch, result register and shift counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr  <= '0;
            r_result <= '0;
`ifdef EXU_ITER_SHIFT_EN
            r_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                EXU_IDLE: begin
                    if (dyn_vld_i) r_instr <= dyn_instr_i;
                end
                EXU_EXEC: begin
                    // For iterative shifts the ALU passes operand A through
                    r_result <= w_alu_res;
`ifdef EXU_ITER_SHIFT_EN
                    r_cnt    <= w_opb[SHCNT_W-1:0];
`endif
                end
`ifdef EXU_ITER_SHIFT_EN
                EXU_SHIFT: begin
                    r_cnt <= r_cnt - SHCNT_W'(1);
                    case (w_aluop)
                        ALUOP_SLL: r_result <= {r_result[DATA_WIDTH-2:0], 1'b0};
                        ALUOP_SRL: r_result <= {1'b0, r_result[DATA_WIDTH-1:1]};
                        default:   r_result <= {r_result[DATA_WIDTH-1], r_result[DATA_WIDTH-1:1]};
                    endcase
                end
`endif
                default: ;
            endcase
        end
    end

endmodule : exu
`default_nettype wire

// File: tb/tb_exu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exu
//  Description : Directed self-checking bench for exu. Cycle 0 is the cycle
//                in which the handshake is presented; observations are taken
//                1 time unit after each rising edge.
//  Macro       : EXU_ITER_SHIFT_EN - selects expected shift latencies
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exu;
    import exu_pkg::*;

`ifdef EXU_ITER_SHIFT_EN
    localparam int ITER = 1;
`else
    localparam int ITER = 0;
`endif

    logic                  clk;
    logic                  rst_n;
    logic [DYN_INST_W-1:0] dyn_instr_i;
    logic                  dyn_vld_i;
    logic                  dyn_rdy_o;
    logic [4:0]            rd_o;
    logic [31:0]           wrtbck_dat_o;
    logic                  wrtbck_en_o;
    logic                  illegal_o;
    logic                  busy_o;

    int n_cmp = 0;
    int n_err = 0;

    exu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dyn_instr_i  (dyn_instr_i),
        .dyn_vld_i    (dyn_vld_i),
        .dyn_rdy_o    (dyn_rdy_o),
        .rd_o         (rd_o),
        .wrtbck_dat_o (wrtbck_dat_o),
        .wrtbck_en_o  (wrtbck_en_o),
        .illegal_o    (illegal_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DYN_INST_W-1:0] mk(
        input logic [3:0] op, input logic [2:0] ty,
        input logic urd, input logic urs1, input logic urs2, input logic uimm, input logic inv,
        input logic [4:0] rd, input logic [31:0] rs1v, input logic [31:0] rs2v,
        input logic [31:0] imm, input logic [31:0] pc);
        logic [DYN_INST_W-1:0] w;
        w = '0;
        w[INVLD_BIT]                 = inv;
        w[USE_RD_BIT]                = urd;
        w[USE_RS1_BIT]               = urs1;
        w[USE_RS2_BIT]               = urs2;
        w[USE_IMM_BIT]               = uimm;
        w[INSTYPE_OFF +: INSTYPE_W]  = ty;
        w[ALUOP_OFF +: ALUOP_W]      = op;
        w[RD_OFF +: 5]               = rd;
        w[PC_OFF +: 32]              = pc;
        w[IMM_OFF +: 32]             = imm;
        w[RS2VAL_OFF +: 32]          = rs2v;
        w[RS1VAL_OFF +: 32]          = rs1v;
        return w;
    endfunction

    // Issue one instruction and observe until the unit is ready again
    task automatic run(input logic [DYN_INST_W-1:0] ins,
                       output int en_cyc, output int en_cnt, output logic [31:0] en_dat,
                       output logic [4:0] en_rd, output int ill_cyc, output int ill_len,
                       output int rdy_cyc);
        en_cyc = -1; en_cnt = 0; en_dat = 'x; en_rd = 'x;
        ill_cyc = -1; ill_len = 0; rdy_cyc = -1;
        @(negedge clk);
        dyn_instr_i = ins;
        dyn_vld_i   = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 45; c++) begin
            #1;
            dyn_vld_i = 1'b0;
            if (wrtbck_en_o) begin
                if (en_cyc < 0) begin
                    en_cyc = c; en_dat = wrtbck_dat_o; en_rd = rd_o;
                end
                en_cnt++;
            end
            if (illegal_o) begin
                if (ill_cyc < 0) ill_cyc = c;
                ill_len++;
            end
            if (dyn_rdy_o) begin
                rdy_cyc = c;
                break;
            end
            @(posedge clk);
        end
    endtask

    // Run a writing instruction and check data, rd and timing
    task automatic exec_check(input string nm, input logic [DYN_INST_W-1:0] ins,
                              input logic [4:0] exp_rd, input logic [31:0] exp_dat,
                              input int exp_wb);
        int ec, cnt, ic, il, rc;
        logic [31:0] d;
        logic [4:0]  r;
        run(ins, ec, cnt, d, r, ic, il, rc);
        n_cmp++;
        if (d !== exp_dat) begin
            n_err++; $display("FAIL %s data: got %08h expected %08h", nm, d, exp_dat);
        end
        n_cmp++;
        if (ec !== exp_wb || cnt !== 1 || r !== exp_rd) begin
            n_err++;
            $display("FAIL %s strobe: cycle %0d count %0d rd %0d expected cycle %0d count 1 rd %0d",
                     nm, ec, cnt, r, exp_wb, exp_rd);
        end
        n_cmp++;
        if (rc !== exp_wb + 1) begin
            n_err++; $display("FAIL %s ready: cycle %0d expected %0d", nm, rc, exp_wb + 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dyn_vld_i = 1'b0; dyn_instr_i = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({dyn_rdy_o, wrtbck_en_o, illegal_o, busy_o} !== 4'b1000) begin
            n_err++; $display("FAIL reset ctrl: rdy/en/ill/busy %b expected 1000",
                              {dyn_rdy_o, wrtbck_en_o, illegal_o, busy_o});
        end
        n_cmp++;
        if (rd_o !== 5'd0 || wrtbck_dat_o !== 32'h0) begin
            n_err++; $display("FAIL reset data: rd %0d data %08h expected 0 0", rd_o, wrtbck_dat_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        exec_check("addi", mk(ALUOP_ADD, INST_I, 1, 1, 0, 1, 0, 5'd1, 32'h0, 32'h0, 32'h5, 32'h0),
                   5'd1, 32'h5, 2);
    endtask

    task automatic test_alu();
        exec_check("sub",  mk(ALUOP_SUB,  INST_R, 1, 1, 1, 0, 0, 5'd2, 32'd3, 32'd5, 32'h0, 32'h0),
                   5'd2, 32'hFFFF_FFFE, 2);
        exec_check("slt",  mk(ALUOP_SLT,  INST_R, 1, 1, 1, 0, 0, 5'd3, 32'd3, 32'd5, 32'h0, 32'h0),
                   5'd3, 32'h1, 2);
        exec_check("sltu", mk(ALUOP_SLTU, INST_R, 1, 1, 1, 0, 0, 5'd4, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0),
                   5'd4, 32'h0, 2);
        exec_check("slt_neg", mk(ALUOP_SLT, INST_R, 1, 1, 1, 0, 0, 5'd4, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0),
                   5'd4, 32'h1, 2);
        exec_check("add_wrap", mk(ALUOP_ADD, INST_R, 1, 1, 1, 0, 0, 5'd5, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0),
                   5'd5, 32'h1, 2);
        exec_check("xor",  mk(ALUOP_XOR, INST_R, 1, 1, 1, 0, 0, 5'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'h0),
                   5'd6, 32'h0FF0_0FF0, 2);
        exec_check("or",   mk(ALUOP_OR,  INST_R, 1, 1, 1, 0, 0, 5'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'h0),
                   5'd7, 32'hFFF0_FFF0, 2);
        exec_check("and",  mk(ALUOP_AND, INST_R, 1, 1, 1, 0, 0, 5'd8, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'h0),
                   5'd8, 32'hF000_F000, 2);
        exec_check("bad_op", mk(4'b1001, INST_R, 1, 1, 1, 0, 0, 5'd9, 32'h1234_5678, 32'h1, 32'h0, 32'h0),
                   5'd9, 32'h0, 2);
    endtask

    task automatic test_shift();
        exec_check("srai4", mk(ALUOP_SRA, INST_I, 1, 1, 0, 1, 0, 5'd10, 32'h8000_0000, 32'h0, 32'd4, 32'h0),
                   5'd10, 32'hF800_0000, ITER ? 6 : 2);
        exec_check("srai0", mk(ALUOP_SRA, INST_I, 1, 1, 0, 1, 0, 5'd11, 32'h8000_0000, 32'h0, 32'd0, 32'h0),
                   5'd11, 32'h8000_0000, 2);
        exec_check("slli31", mk(ALUOP_SLL, INST_I, 1, 1, 0, 1, 0, 5'd12, 32'h0000_0003, 32'h0, 32'd31, 32'h0),
                   5'd12, 32'h8000_0000, ITER ? 33 : 2);
        exec_check("srl8", mk(ALUOP_SRL, INST_R, 1, 1, 1, 0, 0, 5'd13, 32'hF000_0000, 32'd8, 32'h0, 32'h0),
                   5'd13, 32'h00F0_0000, ITER ? 10 : 2);
        // Only the low five bits of operand B form the shift amount
        exec_check("sll_b36", mk(ALUOP_SLL, INST_R, 1, 1, 1, 0, 0, 5'd14, 32'h1, 32'd36, 32'h0, 32'h0),
                   5'd14, 32'h10, ITER ? 6 : 2);
    endtask

    task automatic test_upper();
        exec_check("lui",   mk(ALUOP_ADD, INST_LUI, 1, 1, 0, 1, 0, 5'd15, 32'hDEAD_BEEF, 32'h0, 32'h1234_5000, 32'h0),
                   5'd15, 32'h1234_5000, 2);
        exec_check("auipc", mk(ALUOP_ADD, INST_AUIPC, 1, 0, 0, 1, 0, 5'd16, 32'h0, 32'h0, 32'h0000_1000, 32'h8000_0000),
                   5'd16, 32'h8000_1000, 2);
    endtask

    task automatic test_rd_zero();
        int ec, cnt, ic, il, rc;
        logic [31:0] d;
        logic [4:0]  r;
        run(mk(ALUOP_ADD, INST_I, 1, 1, 0, 1, 0, 5'd0, 32'h0, 32'h0, 32'h5, 32'h0), ec, cnt, d, r, ic, il, rc);
        n_cmp++;
        if (cnt !== 0 || rc !== 3) begin
            n_err++; $display("FAIL rd0 strobe: count %0d ready %0d expected 0 3", cnt, rc);
        end
        n_cmp++;
        if (wrtbck_dat_o !== 32'h5) begin
            n_err++; $display("FAIL rd0 data: got %08h expected 00000005", wrtbck_dat_o);
        end
    endtask

    task automatic test_illegal();
        int ec, cnt, ic, il, rc;
        logic [31:0] d;
        logic [4:0]  r;
        run(mk(ALUOP_ADD, INST_I, 1, 1, 0, 1, 1, 5'd3, 32'h0, 32'h0, 32'h5, 32'h0), ec, cnt, d, r, ic, il, rc);
        n_cmp++;
        if (ic !== 2 || il !== 1) begin
            n_err++; $display("FAIL illegal pulse: cycle %0d width %0d expected 2 1", ic, il);
        end
        n_cmp++;
        if (cnt !== 0 || rc !== 3) begin
            n_err++; $display("FAIL illegal wb: strobes %0d ready %0d expected 0 3", cnt, rc);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] en_mask, rdy_mask;
        en_mask = '0; rdy_mask = '0;
        @(negedge clk);
        dyn_instr_i = mk(ALUOP_ADD, INST_I, 1, 1, 0, 1, 0, 5'd7, 32'd10, 32'h0, 32'd1, 32'h0);
        dyn_vld_i   = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            #1;
            en_mask[c]  = wrtbck_en_o;
            rdy_mask[c] = dyn_rdy_o;
            if (c == 8) dyn_vld_i = 1'b0;
            @(posedge clk);
        end
        #1;
        n_cmp++;
        if (en_mask !== 9'b1_0010_0100) begin
            n_err++; $display("FAIL b2b strobes: mask %b expected 100100100", en_mask);
        end
        n_cmp++;
        if (rdy_mask !== 9'b0_0100_1000) begin
            n_err++; $display("FAIL b2b ready: mask %b expected 001001000", rdy_mask);
        end
        n_cmp++;
        if (dyn_rdy_o !== 1'b1 || wrtbck_dat_o !== 32'd11) begin
            n_err++; $display("FAIL b2b end: ready %b data %08h expected 1 0000000b", dyn_rdy_o, wrtbck_dat_o);
        end
    endtask

    task automatic test_reset_mid_shift();
        int pre_en, post_en;
        pre_en = 0; post_en = 0;
        @(negedge clk);
        dyn_instr_i = mk(ALUOP_SLL, INST_I, 1, 1, 0, 1, 0, 5'd9, 32'h1, 32'h0, 32'd20, 32'h0);
        dyn_vld_i   = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            #1;
            dyn_vld_i = 1'b0;
            if (wrtbck_en_o) pre_en++;
            if (c < 4) @(posedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy_o !== 1'b0 || dyn_rdy_o !== 1'b1) begin
            n_err++; $display("FAIL midreset state: busy %b ready %b expected 0 1", busy_o, dyn_rdy_o);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (wrtbck_en_o) post_en++;
        end
        n_cmp++;
        if (pre_en !== (ITER ? 0 : 1) || post_en !== 0) begin
            n_err++; $display("FAIL midreset strobes: before %0d after %0d expected %0d 0",
                              pre_en, post_en, ITER ? 0 : 1);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_alu();
        test_shift();
        test_upper();
        test_rd_zero();
        test_illegal();
        test_back_to_back();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_exu
`default_nettype wire
